spi_frame_sequencer: RTL and testbench
======================================

// Module: spi_frame_sequencer
// PURPOSE
//  Command sequencer behind the byte-wide SPI front end (cs + 8-bit mosi, one byte per clk).
//  Parses each cs-framed byte stream as opcode, address, data, and drives burst reads and
//  writes into the design's register file with auto-incrementing address. Returns read data
//  on miso. Sits between the top-level pin mapping and the register file.
// PARAMETERS
//  ADDR_WIDTH  8      register file address width; address wraps modulo 2**ADDR_WIDTH
//  ERR_WIDTH   4      width of saturating error counter
// PORTS
//  clk          in   1           clock; cs/mosi are synchronous to it
//  rst          in   1           asynchronous, active-high reset
//  cs           in   1           frame select, active low (frame = contiguous cycles with cs==0)
//  mosi         in   8           command/data byte, sampled every clk edge while cs==0
//  reg_addr     out  ADDR_WIDTH  register file address
//  reg_wr_en    out  1           write strobe, one byte per cycle
//  reg_wr_data  out  8           write data
//  reg_rd_en    out  1           read strobe; register file returns data one cycle later
//  reg_rd_data  in   8           read data, valid the cycle after reg_rd_en
//  miso         out  8           read data returned to host
//  miso_valid   out  1           miso carries a read result this cycle
//  busy         out  1           state != IDLE
//  err_count    out  ERR_WIDTH   count of frames with unknown opcode, saturating
// BEHAVIOUR
//  - All outputs registered; reset value 0 for every output; state <= SYNC on reset.
//  - States: SYNC, IDLE, ADDR, WDATA, RDATA, DRAIN. Edge = rising clk.
//  - SYNC: wait for cs==1 (prevents mid-frame bytes after reset being taken as opcode) -> IDLE.
//  - IDLE: edge with cs==0 latches mosi as opcode -> ADDR.
//  - ADDR: edge with cs==0 latches address A; opcode 8'h01 -> WDATA; 8'h02 -> RDATA and at the
//    same edge reg_rd_en<=1, reg_addr<=A; 8'h00 (NOP) -> DRAIN; other -> DRAIN, err_count+1.
//  - WDATA: each edge with cs==0: reg_wr_en<=1, reg_addr<=addr, reg_wr_data<=mosi, addr++.
//  - RDATA: each edge with cs==0: reg_rd_en<=1, reg_addr<=addr+1, addr++ (mosi ignored).
//    Read result: rd_en at edge E -> reg_rd_data at E+1 -> miso/miso_valid at E+2.
//  - DRAIN: ignore bytes until cs==1.
//  - Any state except SYNC: edge with cs==1 -> IDLE, wr_en/rd_en <=0 at that edge. Read results
//    already in flight still emerge on miso (pipeline flushes, max 2 cycles after cs rises).
//  - Frame ending in ADDR (opcode only) or WDATA with zero data bytes: no access, no error.
//  - cs high for a single cycle ends the frame; next cs==0 byte is a fresh opcode.
//  - Address increment wraps 2**ADDR_WIDTH-1 -> 0 silently; bursts are unbounded.
//  - reg_wr_en and reg_rd_en are never high in the same cycle.
//  - err_count saturates at 2**ERR_WIDTH-1; cleared only by rst.
//  - rst mid-frame: outputs zero immediately (async), in-flight reads discarded, -> SYNC.
// STRUCTURE
//  - Package spi_cmd_pkg: state enum, OP_NOP=8'h00, OP_WRITE=8'h01, OP_READ=8'h02.
//  - One sub-module: spi_read_pipe (2-stage valid/data shift carrying reg_rd_data to miso,
//    with flush on rst). Everything else in this module.
// TESTING
//  - Write burst: cs=0, bytes 01,10,AA,BB,CC, cs=1 -> wr strobes (10,AA),(11,BB),(12,CC) on
//    consecutive cycles starting the edge after 0x10 is sampled; no rd_en; err_count 0.
//  - Read burst: preload 10..12 = AA,BB,CC; bytes 02,10,x,x,x -> rd_en for 10,11,12...;
//    miso_valid with AA,BB,CC, first 2 cycles after rd_en of 0x10; flush after cs rises.
//  - Wrap: bytes 01,FF,11,22 -> writes (FF,11),(00,22).
//  - Bad opcode: bytes 7E,10,55 -> no strobes, err_count 1; repeat 20x -> err_count 15 (sat).
//  - Abort/NOP: 01 then cs=1 -> no access; 00,10,AA -> no access, no error; 1-cycle cs gap
//    between two write frames -> both frames execute.
//  - Reset mid-frame: assert rst during WDATA with cs held 0 -> outputs 0 at once; after
//    release, remaining bytes ignored until cs=1; next frame 01,20,5A writes (20,5A).

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI frame sequencer: FSM state encoding and command opcodes.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

endpackage

// File: rtl/spi_read_pipe.sv
// Two-stage pipe that carries register-file read data back to miso.
// miso_valid is a pure valid strobe (no ready): the host must take miso in the cycle it is high.
module spi_read_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_en,
    input  logic [7:0] rd_data,
    output logic [7:0] miso,
    output logic       miso_valid
);

    logic pend;

    // pend marks the cycle in which rd_data answers the strobe issued one cycle earlier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= 1'b0;
            miso       <= 8'h00;
            miso_valid <= 1'b0;
        end else begin
            pend       <= rd_en;
            miso_valid <= pend;
            miso       <= pend ? rd_data : 8'h00;
        end
    end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Parses cs-framed byte streams (opcode, address, data) into auto-incrementing burst
// reads and writes on the register file port; read data returns on miso.
module spi_frame_sequencer
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int ERR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic [7:0]            mosi,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr_en,
    output logic [7:0]            reg_wr_data,
    output logic                  reg_rd_en,
    input  logic [7:0]            reg_rd_data,
    output logic [7:0]            miso,
    output logic                  miso_valid,
    output logic                  busy,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [2:0]            state_dbg
);

    state_t                state, state_n;
    logic [7:0]            opcode, opcode_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n, reg_addr_n;
    logic                  wr_en_n, rd_en_n;
    logic [7:0]            wr_data_n;
    logic [ERR_WIDTH-1:0]  err_n;

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_SYNC;
            opcode      <= 8'h00;
            addr        <= '0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= 8'h00;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_n;
            opcode      <= opcode_n;
            addr        <= addr_n;
            reg_addr    <= reg_addr_n;
            reg_wr_en   <= wr_en_n;
            reg_wr_data <= wr_data_n;
            reg_rd_en   <= rd_en_n;
            busy        <= (state_n != ST_IDLE);
            err_count   <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        opcode_n   = opcode;
        addr_n     = addr;
        reg_addr_n = reg_addr;
        wr_en_n    = 1'b0;
        wr_data_n  = reg_wr_data;
        rd_en_n    = 1'b0;
        err_n      = err_count;

        if (state == ST_SYNC) begin
            // a frame already running when reset lifts is skipped entirely
            if (cs) state_n = ST_IDLE;
        end else if (cs) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    opcode_n = mosi;
                    state_n  = ST_ADDR;
                end
                ST_ADDR: begin
                    addr_n = ADDR_WIDTH'(mosi);
                    case (opcode)
                        OP_WRITE: state_n = ST_WDATA;
                        OP_READ: begin
                            state_n    = ST_RDATA;
                            rd_en_n    = 1'b1;
                            reg_addr_n = ADDR_WIDTH'(mosi);
                        end
                        OP_NOP:  state_n = ST_DRAIN;
                        default: begin
                            state_n = ST_DRAIN;
                            if (err_count != {ERR_WIDTH{1'b1}}) err_n = err_count + 1'b1;
                        end
                    endcase
                end
                ST_WDATA: begin
                    wr_en_n    = 1'b1;
                    reg_addr_n = addr;
                    wr_data_n  = mosi;
                    addr_n     = addr + 1'b1;
                end
                ST_RDATA: begin
                    // the address byte already issued the first read, so each byte reads the next one
                    rd_en_n    = 1'b1;
                    reg_addr_n = addr + 1'b1;
                    addr_n     = addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    spi_read_pipe u_read_pipe (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (reg_rd_en),
        .rd_data    (reg_rd_data),
        .miso       (miso),
        .miso_valid (miso_valid)
    );

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Bench for spi_frame_sequencer: frame vector table plus hand sequences for reads,
// saturation, back-to-back frames and mid-frame reset, with a register-file model.
module tb_spi_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic [7:0] mosi;
    logic [7:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data;
    logic [7:0] miso;
    logic       miso_valid;
    logic       busy;
    logic [3:0] err_count;
    logic [2:0] state_dbg;

    spi_frame_sequencer #(.ADDR_WIDTH(8), .ERR_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cs          (cs),
        .mosi        (mosi),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .miso        (miso),
        .miso_valid  (miso_valid),
        .busy        (busy),
        .err_count   (err_count),
        .state_dbg   (state_dbg)
    );

    // clock / reset / register file model
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            reg_rd_data <= 8'h00;
        end else begin
            if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
            if (reg_rd_en) reg_rd_data <= mem[reg_addr];
        end
    end

    // scoreboard
    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  exp_miso_q[$];
    int          rd_time_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    task automatic mon();
        int t;
        if (reg_wr_en || reg_rd_en) chk("wr_rd_exclusive", {31'd0, reg_wr_en & reg_rd_en}, 32'd0);
        if (reg_wr_en) begin
            if (exp_wr_q.size() == 0) unexpected("wr_strobe", {16'd0, reg_addr, reg_wr_data});
            else chk("wr_strobe", {16'd0, reg_addr, reg_wr_data}, {16'd0, exp_wr_q.pop_front()});
        end
        if (reg_rd_en) begin
            rd_time_q.push_back(cyc);
            if (exp_rd_q.size() == 0) unexpected("rd_strobe", {24'd0, reg_addr});
            else chk("rd_strobe", {24'd0, reg_addr}, {24'd0, exp_rd_q.pop_front()});
        end
        if (miso_valid) begin
            if (exp_miso_q.size() == 0) unexpected("miso", {24'd0, miso});
            else chk("miso", {24'd0, miso}, {24'd0, exp_miso_q.pop_front()});
            if (rd_time_q.size() == 0) unexpected("miso_latency", 32'd0);
            else begin
                t = rd_time_q.pop_front();
                chk("miso_latency", cyc - t, 32'd2);
            end
        end
    endtask

    // driver tasks: inputs change on the falling edge, after the monitor samples
    task automatic tick(input logic c, input logic [7:0] m);
        @(negedge clk);
        mon();
        cs   = c;
        mosi = m;
    endtask

    task automatic frame(input int nb, input logic [0:5][7:0] b, input int gap);
        for (int i = 0; i < nb; i++) tick(1'b0, b[i]);
        for (int i = 0; i < gap; i++) tick(1'b1, 8'h00);
    endtask

    task automatic chk_queues_empty(input string name);
        chk({name, "_wr_left"}, exp_wr_q.size(), 32'd0);
        chk({name, "_rd_left"}, exp_rd_q.size(), 32'd0);
        chk({name, "_miso_left"}, exp_miso_q.size(), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_addr"}, {24'd0, reg_addr}, 32'd0);
        chk({name, "_wr_en"}, {31'd0, reg_wr_en}, 32'd0);
        chk({name, "_wr_data"}, {24'd0, reg_wr_data}, 32'd0);
        chk({name, "_rd_en"}, {31'd0, reg_rd_en}, 32'd0);
        chk({name, "_miso"}, {24'd0, miso}, 32'd0);
        chk({name, "_miso_valid"}, {31'd0, miso_valid}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_err"}, {28'd0, err_count}, 32'd0);
        chk({name, "_state"}, {29'd0, state_dbg}, 32'd0);
    endtask

    typedef struct packed {
        logic [2:0]        nb;
        logic [0:5][7:0]   b;
        logic [1:0]        nw;
        logic [0:2][15:0]  w;
        logic [3:0]        err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{nb: 3'd5, b: {8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h00},
                    nw: 2'd3, w: {16'h10AA, 16'h11BB, 16'h12CC}, err: 4'd0};
        vecs[1] = '{nb: 3'd4, b: {8'h01, 8'hFF, 8'h11, 8'h22, 8'h00, 8'h00},
                    nw: 2'd2, w: {16'hFF11, 16'h0022, 16'h0000}, err: 4'd0};
        vecs[2] = '{nb: 3'd1, b: {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nw: 2'd0, w: {16'h0000, 16'h0000, 16'h0000}, err: 4'd0};
        vecs[3] = '{nb: 3'd2, b: {8'h01, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00},
                    nw: 2'd0, w: {16'h0000, 16'h0000, 16'h0000}, err: 4'd0};
        vecs[4] = '{nb: 3'd3, b: {8'h00, 8'h10, 8'hAA, 8'h00, 8'h00, 8'h00},
                    nw: 2'd0, w: {16'h0000, 16'h0000, 16'h0000}, err: 4'd0};
        vecs[5] = '{nb: 3'd3, b: {8'h7E, 8'h10, 8'h55, 8'h00, 8'h00, 8'h00},
                    nw: 2'd0, w: {16'h0000, 16'h0000, 16'h0000}, err: 4'd1};

        rst  = 1'b1;
        cs   = 1'b1;
        mosi = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h00);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_state", {29'd0, state_dbg}, 32'd1);

        // table: write burst, wrap, abort, empty write, NOP, bad opcode
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < int'(vecs[v].nw); k++) exp_wr_q.push_back(vecs[v].w[k]);
            frame(int'(vecs[v].nb), vecs[v].b, 4);
            chk($sformatf("vec%0d_err", v), {28'd0, err_count}, {28'd0, vecs[v].err});
            chk($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
            chk_queues_empty($sformatf("vec%0d", v));
        end

        // read burst over 10..13 (10..12 written above, 13 still holds its reset pattern)
        exp_rd_q   = '{8'h10, 8'h11, 8'h12, 8'h13};
        exp_miso_q = '{8'hAA, 8'hBB, 8'hCC, 8'h49};
        tick(1'b0, 8'h02);
        tick(1'b0, 8'h10);
        tick(1'b0, 8'h00);
        chk("read_busy", {31'd0, busy}, 32'd1);
        frame(2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        chk_queues_empty("read");
        chk("read_rdtime_left", rd_time_q.size(), 32'd0);

        // two write frames separated by a single cs-high cycle
        exp_wr_q.push_back(16'h4011);
        exp_wr_q.push_back(16'h4122);
        frame(3, {8'h01, 8'h40, 8'h11, 8'h00, 8'h00, 8'h00}, 1);
        frame(3, {8'h01, 8'h41, 8'h22, 8'h00, 8'h00, 8'h00}, 4);
        chk_queues_empty("gap");

        // error counter saturation
        for (int k = 0; k < 20; k++) begin
            frame(3, {8'h7E, 8'h10, 8'h55, 8'h00, 8'h00, 8'h00}, 1);
            chk($sformatf("err_sat%0d", k), {28'd0, err_count}, (k + 2 > 15) ? 32'd15 : 32'(k + 2));
        end
        tick(1'b1, 8'h00);
        chk_queues_empty("sat");

        // reset in the middle of a write burst
        exp_wr_q.push_back(16'h50A1);
        tick(1'b0, 8'h01);
        tick(1'b0, 8'h50);
        tick(1'b0, 8'hA1);
        tick(1'b0, 8'hA2);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_all_zero("mid_rst");
        chk_queues_empty("mid_rst");
        tick(1'b0, 8'h33);
        tick(1'b0, 8'h33);
        rst = 1'b0;
        tick(1'b0, 8'h44);
        tick(1'b0, 8'h01);
        tick(1'b0, 8'h55);
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
        chk("post_rst_state", {29'd0, state_dbg}, 32'd0);
        tick(1'b0, 8'h66);
        tick(1'b1, 8'h00);
        exp_wr_q.push_back(16'h205A);
        frame(3, {8'h01, 8'h20, 8'h5A, 8'h00, 8'h00, 8'h00}, 4);
        chk_queues_empty("post_rst");
        chk("post_rst_err", {28'd0, err_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
